// File: rtl/mem_arb_ctrl.sv
// Round-robin arbitrated single-port RAM for NUM_CH requesters sharing the CPU-bus
// ren/wen/rdy handshake, with programmable wait states and address mirroring modulo DEPTH.
`timescale 1ns/1ps
module mem_arb_ctrl #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 2048,
   parameter int WAIT_CYCLES = 0,
   localparam int GNT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ren,
   input  logic [NUM_CH-1:0]        wen,
   input  logic [NUM_CH*ADDR_W-1:0] addr_in,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   output logic [NUM_CH-1:0]        rdy,
   output logic [DATA_W-1:0]        data_out,
   output logic [GNT_W-1:0]         gnt_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t              state_r;
   logic [3:0]          cnt_r;
   logic [GNT_W-1:0]    ptr_r;
   logic [GNT_W-1:0]    gnt_r;
   logic                op_wr_r;
   logic [IDX_W-1:0]    idx_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [DATA_W-1:0]   dout_r;
   logic [NUM_CH-1:0]   rdy_r;
   logic [DATA_W-1:0]   mem_r [DEPTH];

   logic [NUM_CH-1:0]   pend_s;
   logic [GNT_W-1:0]    pick_s;
   logic                any_s;
   logic [IDX_W-1:0]    pick_idx_s;
   logic [DATA_W-1:0]   pick_data_s;
   logic                is_idle_s;
   logic [GNT_W-1:0]    cur_gnt_s;
   logic                cur_wr_s;
   logic [IDX_W-1:0]    cur_idx_s;
   logic [DATA_W-1:0]   cur_data_s;
   logic                go_s;

   assign pend_s = ren | wen;

   // Round-robin pick: scanning downward lets the channel nearest after ptr_r win.
   always_comb begin
      int               k_v;
      logic [GNT_W-1:0] ks_v;
      pick_s = '0;
      any_s  = 1'b0;
      k_v    = 0;
      ks_v   = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         k_v    = int'(ptr_r) + i;
         k_v    = (k_v >= NUM_CH) ? (k_v - NUM_CH) : k_v;
         ks_v   = k_v[GNT_W-1:0];
         pick_s = pend_s[ks_v] ? ks_v : pick_s;
         any_s  = any_s | pend_s[ks_v];
      end
   end

   assign pick_idx_s  = addr_in[int'(pick_s)*ADDR_W +: IDX_W];
   assign pick_data_s = data_in[int'(pick_s)*DATA_W +: DATA_W];

   // With zero wait states the access completes on the grant edge, so use live inputs there.
   assign is_idle_s  = (state_r == ST_IDLE);
   assign cur_gnt_s  = is_idle_s ? pick_s      : gnt_r;
   assign cur_wr_s   = is_idle_s ? wen[pick_s] : op_wr_r;
   assign cur_idx_s  = is_idle_s ? pick_idx_s  : idx_r;
   assign cur_data_s = is_idle_s ? pick_data_s : wdata_r;
   assign go_s       = (is_idle_s && any_s && (WAIT_CYCLES == 0)) ||
                       ((state_r == ST_WAIT) && (cnt_r == 4'd1));

   // RAM commit on the edge entering ACK; gated by rst so an aborted access never lands.
   always_ff @(posedge clk) begin
      if (rst && go_s && cur_wr_s) begin
         mem_r[cur_idx_s] <= cur_data_s;
      end
   end

   // Arbitration FSM with registered rdy, read data and grant index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         ptr_r   <= GNT_W'(NUM_CH - 1);
         gnt_r   <= '0;
         op_wr_r <= 1'b0;
         idx_r   <= '0;
         wdata_r <= '0;
         dout_r  <= '0;
         rdy_r   <= '0;
      end else begin
         rdy_r <= '0;
         if (go_s) begin
            ptr_r <= cur_gnt_s;
            rdy_r <= NUM_CH'(1) << cur_gnt_s;
            if (!cur_wr_s) begin
               dout_r <= mem_r[cur_idx_s];
            end
         end
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  gnt_r   <= pick_s;
                  op_wr_r <= wen[pick_s];
                  idx_r   <= pick_idx_s;
                  wdata_r <= pick_data_s;
                  cnt_r   <= 4'(WAIT_CYCLES);
                  state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
               end
            end
            ST_WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  state_r <= ST_ACK;
               end
            end
            ST_ACK:  state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign rdy      = rdy_r;
   assign data_out = dout_r;
   assign gnt_id   = gnt_r;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench: two arbiter instances (2 ch / 0 waits, 4 ch / 3 waits) driven by
// directed and random requests, compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arb_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst1;
   logic [3:0]  ren_v [2];
   logic [3:0]  wen_v [2];
   logic [15:0] addr_v [2][4];
   logic [7:0]  wd_v [2][4];

   logic [1:0]  rdy0;
   logic [7:0]  dout0;
   logic        gnt0;
   logic [3:0]  rdy1;
   logic [7:0]  dout1;
   logic [1:0]  gnt1;

   // reference model state
   logic [7:0]  rmem [2][2048];
   int          mptr [2];
   logic [7:0]  mdout [2];
   int          nch [2] = '{2, 4};
   int          wt  [2] = '{0, 3};

   int n_chk  = 0;
   int n_fail = 0;

   mem_arb_ctrl #(.NUM_CH(2), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0),
      .ren(ren_v[0][1:0]), .wen(wen_v[0][1:0]),
      .addr_in({addr_v[0][1], addr_v[0][0]}),
      .data_in({wd_v[0][1], wd_v[0][0]}),
      .rdy(rdy0), .data_out(dout0), .gnt_id(gnt0)
   );

   mem_arb_ctrl #(.NUM_CH(4), .WAIT_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst1),
      .ren(ren_v[1]), .wen(wen_v[1]),
      .addr_in({addr_v[1][3], addr_v[1][2], addr_v[1][1], addr_v[1][0]}),
      .data_in({wd_v[1][3], wd_v[1][2], wd_v[1][1], wd_v[1][0]}),
      .rdy(rdy1), .data_out(dout1), .gnt_id(gnt1)
   );

   function automatic logic [3:0] obs_rdy(input int w);
      return (w == 0) ? {2'b00, rdy0} : rdy1;
   endfunction

   function automatic logic [1:0] obs_gnt(input int w);
      return (w == 0) ? {1'b0, gnt0} : gnt1;
   endfunction

   function automatic logic [7:0] obs_dout(input int w);
      return (w == 0) ? dout0 : dout1;
   endfunction

   function automatic logic [10:0] pool_idx(input int i);
      return 11'((i * 131) % 2048);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input int w, input int k, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [7:0] d);
      ren_v[w][k]  = rd;
      wen_v[w][k]  = wr;
      addr_v[w][k] = a;
      wd_v[w][k]   = d;
   endtask

   function automatic bit any_pending(input int w);
      return (ren_v[w] | wen_v[w]) != 4'd0;
   endfunction

   // Called at a falling edge while the DUT idles with requests pending: one full access.
   task automatic serve(input int w, input bit keep);
      int          g;
      int          k;
      logic        wr;
      logic [10:0] idx;
      logic [7:0]  d;
      g = 0;
      for (int i = nch[w]; i >= 1; i--) begin
         k = (mptr[w] + i) % nch[w];
         if (ren_v[w][k] | wen_v[w][k]) g = k;
      end
      wr  = wen_v[w][g];
      idx = addr_v[w][g][10:0];
      d   = wd_v[w][g];
      for (int c = 1; c <= wt[w] + 1; c++) begin
         @(negedge clk);
         if (c <= wt[w]) begin
            chk("rdy_during_wait", 32'(obs_rdy(w)), 32'd0);
            if (!keep) begin
               addr_v[w][g] = 16'($urandom);
               wd_v[w][g]   = 8'($urandom);
            end
         end
      end
      if (wr) rmem[w][idx] = d;
      else    mdout[w] = rmem[w][idx];
      mptr[w] = g;
      chk("rdy_pulse", 32'(obs_rdy(w)), 32'd1 << g);
      chk("gnt_id", 32'(obs_gnt(w)), 32'(g));
      chk("data_out", 32'(obs_dout(w)), 32'(mdout[w]));
      if (!keep) begin
         ren_v[w][g] = 1'b0;
         wen_v[w][g] = 1'b0;
      end
      @(negedge clk);
      chk("rdy_single_cycle", 32'(obs_rdy(w)), 32'd0);
   endtask

   task automatic do_reset(input int w);
      for (int k = 0; k < 4; k++) req(w, k, 1'b0, 1'b0, 16'd0, 8'd0);
      if (w == 0) rst0 = 1'b0; else rst1 = 1'b0;
      #1;
      chk("reset_rdy", 32'(obs_rdy(w)), 32'd0);
      chk("reset_gnt", 32'(obs_gnt(w)), 32'd0);
      chk("reset_dout", 32'(obs_dout(w)), 32'd0);
      @(negedge clk);
      if (w == 0) rst0 = 1'b1; else rst1 = 1'b1;
      mptr[w]  = nch[w] - 1;
      mdout[w] = 8'd0;
   endtask

   initial begin
      rst0 = 1'b0;
      rst1 = 1'b0;
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 4; k++) req(w, k, 1'b0, 1'b0, 16'd0, 8'd0);
         for (int j = 0; j < 2048; j++) rmem[w][j] = 8'hxx;
      end
      @(negedge clk);
      @(negedge clk);
      do_reset(0);
      do_reset(1);

      // write, then read back through a mirrored address
      req(0, 0, 1'b0, 1'b1, 16'h0010, 8'hA5);
      serve(0, 1'b0);
      req(0, 0, 1'b1, 1'b0, 16'h0810, 8'h00);
      serve(0, 1'b0);

      // ren and wen together act as a write
      req(0, 0, 1'b1, 1'b1, 16'h0005, 8'h7E);
      serve(0, 1'b0);
      req(0, 0, 1'b1, 1'b0, 16'h0005, 8'h00);
      serve(0, 1'b0);

      // continuous requests from reset must alternate grants
      do_reset(0);
      req(0, 0, 1'b0, 1'b1, 16'h0100, 8'h12);
      req(0, 1, 1'b0, 1'b1, 16'h0101, 8'h34);
      for (int n = 0; n < 6; n++) serve(0, 1'b1);
      req(0, 0, 1'b0, 1'b0, 16'd0, 8'd0);
      req(0, 1, 1'b0, 1'b0, 16'd0, 8'd0);

      // wait states: ch1 reads 0x0000 after ch3 wrote it
      req(1, 3, 1'b0, 1'b1, 16'h0000, 8'h5A);
      serve(1, 1'b0);
      req(1, 1, 1'b1, 1'b0, 16'h0000, 8'h00);
      serve(1, 1'b0);

      // ptr=1 with ch1 and ch3 pending: ch3 first, then ch1
      req(1, 1, 1'b1, 1'b0, 16'h0000, 8'h00);
      req(1, 3, 1'b1, 1'b0, 16'h0000, 8'h00);
      serve(1, 1'b0);
      serve(1, 1'b0);

      // reset during a write's wait states aborts the write
      req(1, 2, 1'b0, 1'b1, 16'h0020, 8'h11);
      serve(1, 1'b0);
      req(1, 2, 1'b1, 1'b0, 16'h0020, 8'h00);
      serve(1, 1'b0);
      req(1, 0, 1'b0, 1'b1, 16'h0020, 8'h3C);
      @(negedge clk);
      #2;
      do_reset(1);
      req(1, 1, 1'b1, 1'b0, 16'h0020, 8'h00);
      serve(1, 1'b0);

      // random traffic over a pre-written address pool
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 16; i++) begin
            req(w, i % nch[w], 1'b0, 1'b1, {5'($urandom), pool_idx(i)}, 8'($urandom));
            serve(w, 1'b0);
         end
         for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < nch[w]; k++) begin
               if (!(ren_v[w][k] | wen_v[w][k]) && ($urandom_range(1, 0) == 1)) begin
                  case ($urandom_range(2, 0))
                     0:       req(w, k, 1'b1, 1'b0, {5'($urandom), pool_idx($urandom_range(15, 0))}, 8'($urandom));
                     1:       req(w, k, 1'b0, 1'b1, {5'($urandom), pool_idx($urandom_range(15, 0))}, 8'($urandom));
                     default: req(w, k, 1'b1, 1'b1, {5'($urandom), pool_idx($urandom_range(15, 0))}, 8'($urandom));
                  endcase
               end
            end
            if (any_pending(w)) serve(w, 1'b0);
         end
         for (int n = 0; n < 8; n++) begin
            if (any_pending(w)) serve(w, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
